// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared pipeline types and load/store helpers
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halves must sit on even addresses, words on multiples of four; bytes never fault.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated so the byte-enabled lane always carries the data.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - data memory request/acknowledge bus
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_load_align.sv
// rtl/dmem_access_ctrl_load_align.sv - lane select and sign/zero extension of load data
module load_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend according to the load type.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data memory access FSM with stall and timeout
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          Funct3M,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  dmem_access_ctrl_if.master  mem,
  output logic                StallMem,
  output logic [31:0]         dmem_data_out,
  output logic                MemErr
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic [31:0] data_q;
  logic [31:0] load_data;

  logic access, bad_align, start, expire;

  assign access    = MemReadM | MemWriteM;
  assign bad_align = misaligned(Funct3M, ALUResultM[1:0]);
  assign start     = (state_q == ST_IDLE) && access && !bad_align;
  assign expire    = (state_q == ST_REQ) && !mem.mem_ack && (cnt_q == TO_LAST);

  load_align u_load_align (
    .rdata  (mem.mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the combinational stall and error outputs; both are held low during reset.
  always_comb begin
    state_d  = state_q;
    StallMem = 1'b0;
    MemErr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_REQ;
          StallMem = 1'b1;
        end
        MemErr = access && bad_align;
      end
      ST_REQ: begin
        StallMem = 1'b1;
        if (mem.mem_ack || expire) state_d = ST_DONE;
        MemErr = expire;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      StallMem = 1'b0;
      MemErr   = 1'b0;
    end
  end

  // Request latching, ack/timeout handling and load result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_be    <= 4'h0;
      cnt_q         <= 8'h0;
      offset_q      <= 2'b00;
      funct3_q      <= 3'b000;
      data_q        <= 32'h0;
    end else if (start) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= MemWriteM;
      mem.mem_addr  <= {ALUResultM[31:2], 2'b00};
      mem.mem_wdata <= store_data(Funct3M, WriteDataM);
      mem.mem_be    <= byte_en(Funct3M, ALUResultM[1:0]);
      cnt_q         <= 8'h0;
      offset_q      <= ALUResultM[1:0];
      funct3_q      <= Funct3M;
    end else if (state_q == ST_REQ) begin
      if (mem.mem_ack) begin
        mem.mem_req <= 1'b0;
        if (!mem.mem_we) data_q <= load_data;
      end else if (expire) begin
        mem.mem_req <= 1'b0;
        data_q      <= 32'h0;
      end else begin
        cnt_q <= cnt_q + 8'h1;
      end
    end
  end

  assign dmem_data_out = data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_a, wr_a, rd_b, wr_b;
  logic [2:0]  f3_a, f3_b;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic        stall_a, err_a, stall_b, err_b;
  logic [31:0] dout_a, dout_b;

  dmem_access_ctrl_if bus_a ();
  dmem_access_ctrl_if bus_b ();

  dmem_access_ctrl dut_a (
    .clk (clk), .rst (rst), .MemReadM (rd_a), .MemWriteM (wr_a), .Funct3M (f3_a),
    .ALUResultM (addr_a), .WriteDataM (wd_a), .mem (bus_a.master),
    .StallMem (stall_a), .dmem_data_out (dout_a), .MemErr (err_a)
  );

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk (clk), .rst (rst), .MemReadM (rd_b), .MemWriteM (wr_b), .Funct3M (f3_b),
    .ALUResultM (addr_b), .WriteDataM (wd_b), .mem (bus_b.master),
    .StallMem (stall_b), .dmem_data_out (dout_b), .MemErr (err_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int          stall_n, req_n, err_n;
  logic        s_stall, s_req, s_err, s_we;
  logic [31:0] s_addr, s_wdata, s_data;
  logic [3:0]  s_be;
  logic        cap_we, done_req, post_stall, post_req;
  logic [31:0] cap_addr, cap_wdata, done_data, post_data;
  logic [3:0]  cap_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin
      s_stall = stall_b; s_req = bus_b.mem_req; s_err = err_b; s_we = bus_b.mem_we;
      s_addr = bus_b.mem_addr; s_wdata = bus_b.mem_wdata; s_be = bus_b.mem_be; s_data = dout_b;
    end else begin
      s_stall = stall_a; s_req = bus_a.mem_req; s_err = err_a; s_we = bus_a.mem_we;
      s_addr = bus_a.mem_addr; s_wdata = bus_a.mem_wdata; s_be = bus_a.mem_be; s_data = dout_a;
    end
  endtask

  // One access held for ncyc cycles (IDLE..DONE); ack pulses on cycle ack_at (-1 = never).
  task automatic run(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                     input int ack_at, input int ncyc);
    stall_n = 0; req_n = 0; err_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (sel) begin
        rd_b = rd; wr_b = wr; f3_b = f3; addr_b = addr; wd_b = wd;
        bus_b.mem_ack = (c == ack_at); bus_b.mem_rdata = rdata;
      end else begin
        rd_a = rd; wr_a = wr; f3_a = f3; addr_a = addr; wd_a = wd;
        bus_a.mem_ack = (c == ack_at); bus_a.mem_rdata = rdata;
      end
      @(negedge clk);
      sample(sel);
      stall_n += int'(s_stall);
      req_n   += int'(s_req);
      err_n   += int'(s_err);
      if (c == 1) begin
        cap_addr = s_addr; cap_wdata = s_wdata; cap_be = s_be; cap_we = s_we;
      end
      if (c == ncyc - 1) begin
        done_data = s_data; done_req = s_req;
      end
      @(posedge clk); #1;
    end
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    bus_a.mem_ack = 1'b0; bus_b.mem_ack = 1'b0;
    @(negedge clk);
    sample(sel);
    post_stall = s_stall; post_req = s_req; post_data = s_data;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_a = 1'b1; wr_a = 1'b0; f3_a = F3_W; addr_a = 32'h100; wd_a = 32'h0;
    rd_b = 1'b0; wr_b = 1'b0; f3_b = F3_W; addr_b = 32'h0;   wd_b = 32'h0;
    bus_a.mem_ack = 1'b0; bus_a.mem_rdata = 32'h0;
    bus_b.mem_ack = 1'b0; bus_b.mem_rdata = 32'h0;

    // Reset state, with an aligned load presented to prove the stall stays low.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_req",   32'(bus_a.mem_req), 32'h0);
    chk("rst_addr",  bus_a.mem_addr, 32'h0);
    chk("rst_be",    32'(bus_a.mem_be), 32'h0);
    chk("rst_dout",  dout_a, 32'h0);
    chk("rst_err",   32'(err_a), 32'h0);
    @(posedge clk); #1;
    rd_a = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // LW 0x100, ack on first REQ cycle.
    run(1'b0, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1, 3);
    chk("lw_stall_cycles", 32'(stall_n), 32'd2);
    chk("lw_req_cycles",   32'(req_n), 32'd1);
    chk("lw_addr",         cap_addr, 32'h100);
    chk("lw_be",           32'(cap_be), 32'hF);
    chk("lw_we",           32'(cap_we), 32'h0);
    chk("lw_done_data",    done_data, 32'hDEADBEEF);
    chk("lw_done_req",     32'(done_req), 32'h0);
    chk("lw_err",          32'(err_n), 32'h0);
    chk("lw_retain",       post_data, 32'hDEADBEEF);
    chk("lw_post_stall",   32'(post_stall), 32'h0);

    // Byte and half loads from the upper lanes, signed and unsigned.
    run(1'b0, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 1, 3);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_be",   32'(cap_be), 32'h8);
    chk("lb_data", done_data, 32'hFFFFFF80);
    run(1'b0, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 1, 3);
    chk("lbu_data", done_data, 32'h00000080);
    run(1'b0, 1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h80FF_0000, 1, 3);
    chk("lh_be",   32'(cap_be), 32'hC);
    chk("lh_data", done_data, 32'hFFFF80FF);
    run(1'b0, 1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF_0000, 1, 3);
    chk("lhu_data", done_data, 32'h000080FF);

    // Ack while idle must not start anything or disturb the held load data.
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("idle_ack_req", 32'(bus_a.mem_req), 32'h0);
    @(posedge clk); #1;
    bus_a.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_dout",  dout_a, 32'h000080FF);
    chk("idle_ack_stall", 32'(stall_a), 32'h0);
    @(posedge clk); #1;

    // SH 0x102 with four wait cycles before ack.
    run(1'b0, 1'b0, 1'b1, F3_H, 32'h102, 32'h1234ABCD, 32'h0, 5, 7);
    chk("sh_stall_cycles", 32'(stall_n), 32'd6);
    chk("sh_req_cycles",   32'(req_n), 32'd5);
    chk("sh_be",           32'(cap_be), 32'hC);
    chk("sh_wdata",        cap_wdata, 32'hABCDABCD);
    chk("sh_we",           32'(cap_we), 32'h1);
    chk("sh_addr",         cap_addr, 32'h100);

    // Read and write together is a store.
    run(1'b0, 1'b1, 1'b1, F3_B, 32'h101, 32'h000000CD, 32'h0, 1, 3);
    chk("sb_we",    32'(cap_we), 32'h1);
    chk("sb_be",    32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hCDCDCDCD);

    // Misaligned word then misaligned half: single-cycle error, no request, no stall.
    rd_a = 1'b1; f3_a = F3_W; addr_a = 32'h101;
    @(negedge clk);
    chk("mis_lw_err",   32'(err_a), 32'h1);
    chk("mis_lw_stall", 32'(stall_a), 32'h0);
    @(posedge clk); #1;
    f3_a = F3_H; addr_a = 32'h103;
    @(negedge clk);
    chk("mis_lw_req",   32'(bus_a.mem_req), 32'h0);
    chk("mis_lh_err",   32'(err_a), 32'h1);
    @(posedge clk); #1;
    rd_a = 1'b0;
    @(negedge clk);
    chk("mis_err_clear", 32'(err_a), 32'h0);
    chk("mis_req_none",  32'(bus_a.mem_req), 32'h0);
    chk("mis_stall_off", 32'(stall_a), 32'h0);
    @(posedge clk); #1;

    // Reset on the second REQ cycle; the ack that follows must be ignored.
    rd_a = 1'b1; wr_a = 1'b0; f3_a = F3_W; addr_a = 32'h200;
    @(negedge clk);
    chk("rq_idle_stall", 32'(stall_a), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq_req1", 32'(bus_a.mem_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rq_rst_stall", 32'(stall_a), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rd_a = 1'b0; bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rq_req",   32'(bus_a.mem_req), 32'h0);
    chk("rq_we",    32'(bus_a.mem_we), 32'h0);
    chk("rq_addr",  bus_a.mem_addr, 32'h0);
    chk("rq_wdata", bus_a.mem_wdata, 32'h0);
    chk("rq_be",    32'(bus_a.mem_be), 32'h0);
    chk("rq_dout",  dout_a, 32'h0);
    chk("rq_stall", 32'(stall_a), 32'h0);
    chk("rq_err",   32'(err_a), 32'h0);
    @(posedge clk); #1;
    bus_a.mem_ack = 1'b0;
    @(negedge clk);
    chk("rq_late_req",  32'(bus_a.mem_req), 32'h0);
    chk("rq_late_dout", dout_a, 32'h0);
    @(posedge clk); #1;

    // Short-timeout instance: a good load, then one that never gets acked.
    run(1'b1, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h5A5AA5A5, 1, 3);
    chk("to_pre_data", done_data, 32'h5A5AA5A5);
    run(1'b1, 1'b1, 1'b0, F3_W, 32'h80, 32'h0, 32'h0, -1, 6);
    chk("to_req_cycles",   32'(req_n), 32'd4);
    chk("to_err_pulses",   32'(err_n), 32'd1);
    chk("to_stall_cycles", 32'(stall_n), 32'd5);
    chk("to_addr",         cap_addr, 32'h80);
    chk("to_done_data",    done_data, 32'h0);
    chk("to_done_req",     32'(done_req), 32'h0);
    chk("to_post_stall",   32'(post_stall), 32'h0);
    chk("to_post_req",     32'(post_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum cycles mem_req is held awaiting mem_ack before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports MemReadM, MemWriteM  input  1 each  load/store in MEM stage.
REQ-005 SHALL have port Funct3M  input  3  access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-006 SHALL have ports ALUResultM (address), WriteDataM  input  32 each.
REQ-007 SHALL have ports mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; mem_be  output  4.
REQ-008 SHALL have ports mem_ack  input  1; mem_rdata  input  32.
REQ-009 SHALL have ports StallMem  output  1  freezes IF..MEM registers and bubbles MEM/WB; dmem_data_out  output  32  aligned, extended load data; MemErr  output  1  one-cycle error pulse.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, DONE.
REQ-011 IDLE: when (MemReadM|MemWriteM) and aligned, SHALL assert StallMem combinationally, latch address/data/byte-enables/funct3, go to REQ next cycle.
REQ-012 REQ: SHALL drive mem_req=1 with stable latched mem_addr (word-aligned, bits[1:0]=0), mem_wdata, mem_be, mem_we until mem_ack; StallMem=1 throughout.
REQ-013 On mem_ack in REQ: SHALL capture mem_rdata, go to DONE; mem_req deasserts next cycle.
REQ-014 DONE: StallMem=0, mem_req=0, dmem_data_out holds extended load data; next state IDLE unconditionally.
REQ-015 Minimum latency SHALL be 3 cycles in MEM (IDLE, REQ with same-cycle ack, DONE); each extra ack wait adds one cycle.
REQ-016 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; mem_wdata SHALL replicate byte/half across lanes.
REQ-017 Loads SHALL select lane by latched addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
REQ-018 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no mem_req, pulse MemErr one cycle, not stall, stay IDLE.
REQ-019 Timeout counter SHALL count REQ cycles; if TIMEOUT_CYCLES elapse without ack, SHALL drop mem_req, pulse MemErr, go to DONE with dmem_data_out=0.
REQ-020 mem_ack outside REQ SHALL be ignored.
REQ-021 MemReadM and MemWriteM both high SHALL be treated as a store.
REQ-022 In IDLE with no access, StallMem=0 and dmem_data_out retains last value.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, dmem_data_out=0, MemErr=0.
REQ-024 rst mid-REQ SHALL abandon the transaction; mem_req low the cycle after the reset edge; late ack ignored.
REQ-025 StallMem SHALL be 0 while rst is asserted.

Structure
REQ-026 State enum and Funct3 load/store encodings SHALL live in the shared pipeline package.
REQ-027 Load alignment/extension SHALL be one sub-module, load_align, combinational; FSM and counter in top.

Verification
REQ-028 LW addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> StallMem high 2 cycles, dmem_data_out 0xDEADBEEF in DONE.
REQ-029 LB addr 0x103, rdata 0x80FF_0000 -> mem_addr 0x100, dmem_data_out 0xFFFFFF80; LBU -> 0x00000080.
REQ-030 SH addr 0x102, WriteDataM 0x1234ABCD, ack after 4 cycles -> mem_be 1100, mem_wdata 0xABCDABCD, StallMem high 6 cycles.
REQ-031 LW addr 0x101 -> no mem_req, MemErr one cycle, StallMem 0.
REQ-032 TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, MemErr pulse, dmem_data_out 0, back to IDLE.
REQ-033 rst asserted on 2nd REQ cycle, ack arrives next cycle -> all outputs at reset values, ack ignored, StallMem 0.
